row_window_buffer: RTL

- Sits between the shared image memory (port a) and the edge-detection accelerator.
- Prefetches input image rows into an on-chip 4-row ring and presents three vertically adjacent 32-bit words (row above, current, below) per column request.
- Also collects result words from the accelerator and writes them back to the output region of memory, arbitrating one memory port between prefetch reads and write-back.

---
 rtl/row_window_buffer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/row_window_buffer.sv
// Row window buffer: prefetches image rows into a 4-row ring, serves vertical
// word triples to the edge accelerator and writes results back over one memory port.
module row_window_buffer #(
  parameter int WIDTH    = 352,
  parameter int HEIGHT   = 288,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 25344
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_di,
  input  logic [31:0] mem_do,
  output logic        row_cached,
  input  logic        req,
  output logic        rd_valid,
  output logic [31:0] row_a,
  output logic [31:0] row_b,
  output logic [31:0] row_c,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        done
);

  localparam int WPR   = WIDTH / 4;
  localparam int TOTAL = HEIGHT * WPR;
  localparam int CW    = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RW    = $clog2(HEIGHT + 3);
  localparam int NW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] LAST_COL = CW'(WPR - 1);
  localparam logic [RW-1:0] H_L      = RW'(HEIGHT);
  localparam logic [RW-1:0] TWO_L    = RW'(2);
  localparam logic [RW-1:0] ONE_L    = RW'(1);
  localparam logic [NW-1:0] TOTAL_L  = NW'(TOTAL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          r_start_q;
  // Prefetch side: row pointer p, column and linear read address.
  logic [RW-1:0] r_p;
  logic [CW-1:0] r_pcol;
  logic [15:0]   r_rd_addr;
  logic          r_fill_pend;
  logic          r_fill_last;
  logic [1:0]    r_fill_slot;
  logic [CW-1:0] r_fill_col;
  logic [RW-1:0] r_rows_loaded;
  // Read side: current output row r and column c.
  logic [RW-1:0] r_r;
  logic [CW-1:0] r_c;
  logic          r_rd_valid;
  logic [31:0]   r_row_a;
  logic [31:0]   r_row_b;
  logic [31:0]   r_row_c;
  // Write side: one-entry slot and result counter.
  logic [NW-1:0] r_w;
  logic          r_slot_full;
  logic [15:0]   r_slot_addr;
  logic [31:0]   r_slot_data;
  logic          r_done;

  logic [31:0]   r_ring [4][WPR];

  logic          w_start_rise;
  logic [RW-1:0] w_need;
  logic          w_row_cached;
  logic          w_pf_ok;
  logic          w_rd_issue;
  logic          w_req_accept;
  logic          w_wr_ready;
  logic          w_wr_accept;
  logic          w_frame_end;
  logic [1:0]    w_slot_a;
  logic [1:0]    w_slot_b;
  logic [1:0]    w_slot_c;

  assign w_start_rise = start && !r_start_q;

  // Rows 0..min(r+1, HEIGHT-1) must be resident before a column is served.
  assign w_need       = ((r_r + TWO_L) > H_L) ? H_L : (r_r + TWO_L);
  assign w_row_cached = (r_state == S_RUN) && (r_r < H_L) && (r_rows_loaded >= w_need);

  // Stalling while p > r+2 keeps the slot of row r-1 intact.
  assign w_pf_ok = (((r_state == S_FILL) && (r_p < TWO_L)) || (r_state == S_RUN))
                   && (r_p < H_L) && (r_p <= r_r + TWO_L);
  assign w_rd_issue   = w_pf_ok && !r_slot_full;
  assign w_req_accept = req && w_row_cached;

  assign w_wr_ready  = (r_state != S_IDLE) && !r_slot_full && (r_w < TOTAL_L);
  assign w_wr_accept = wr_en && w_wr_ready;
  assign w_frame_end = (r_w == TOTAL_L) && !r_slot_full;

  assign w_slot_a = (r_r == '0) ? 2'd0 : 2'(r_r - ONE_L);
  assign w_slot_b = r_r[1:0];
  assign w_slot_c = (r_r == H_L - ONE_L) ? r_r[1:0] : 2'(r_r + ONE_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_di      = '0;

    unique case (r_state)
      S_IDLE:  if (w_start_rise)         w_state_nxt = S_FILL;
      S_FILL:  if (r_p >= TWO_L)         w_state_nxt = S_RUN;
      S_RUN:   if (r_r == H_L)           w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_frame_end)          w_state_nxt = S_IDLE;
      default:                           w_state_nxt = S_IDLE;
    endcase

    // A pending write-back always wins the port; prefetch takes the leftover cycles.
    if (r_slot_full) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = r_slot_addr;
      mem_di   = r_slot_data;
    end else if (w_pf_ok) begin
      mem_en   = 1'b1;
      mem_addr = r_rd_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_q     <= 1'b0;
      r_p           <= '0;
      r_pcol        <= '0;
      r_rd_addr     <= '0;
      r_fill_pend   <= 1'b0;
      r_fill_last   <= 1'b0;
      r_fill_slot   <= '0;
      r_fill_col    <= '0;
      r_rows_loaded <= '0;
      r_r           <= '0;
      r_c           <= '0;
      r_rd_valid    <= 1'b0;
      r_row_a       <= '0;
      r_row_b       <= '0;
      r_row_c       <= '0;
      r_w           <= '0;
      r_slot_full   <= 1'b0;
      r_slot_addr   <= '0;
      r_slot_data   <= '0;
      r_done        <= 1'b0;
    end else begin
      r_start_q   <= start;
      r_rd_valid  <= 1'b0;
      r_fill_pend <= 1'b0;

      if ((r_state == S_IDLE) && w_start_rise) begin
        r_p           <= '0;
        r_pcol        <= '0;
        r_rd_addr     <= 16'(IN_BASE);
        r_rows_loaded <= '0;
        r_r           <= '0;
        r_c           <= '0;
        r_w           <= '0;
        r_slot_full   <= 1'b0;
        r_done        <= 1'b0;
      end else begin
        if (w_rd_issue) begin
          r_fill_pend <= 1'b1;
          r_fill_slot <= r_p[1:0];
          r_fill_col  <= r_pcol;
          r_fill_last <= (r_pcol == LAST_COL);
          r_rd_addr   <= r_rd_addr + 16'd1;
          if (r_pcol == LAST_COL) begin
            r_pcol <= '0;
            r_p    <= r_p + ONE_L;
          end else begin
            r_pcol <= r_pcol + CW'(1);
          end
        end

        // A row counts as resident once its last word lands in the ring.
        if (r_fill_pend && r_fill_last)
          r_rows_loaded <= r_rows_loaded + ONE_L;

        if (w_req_accept) begin
          r_rd_valid <= 1'b1;
          r_row_a    <= r_ring[w_slot_a][r_c];
          r_row_b    <= r_ring[w_slot_b][r_c];
          r_row_c    <= r_ring[w_slot_c][r_c];
          if (r_c == LAST_COL) begin
            r_c <= '0;
            r_r <= r_r + ONE_L;
          end else begin
            r_c <= r_c + CW'(1);
          end
        end

        if (r_slot_full) begin
          r_slot_full <= 1'b0;
        end else if (w_wr_accept) begin
          r_slot_full <= 1'b1;
          r_slot_addr <= 16'(OUT_BASE) + 16'(r_w);
          r_slot_data <= wr_data;
          r_w         <= r_w + NW'(1);
        end

        if ((r_state == S_FLUSH) && w_frame_end)
          r_done <= 1'b1;
      end
    end
  end

  // NOTE: ring storage has no reset; residency is tracked by r_rows_loaded instead,
  // which keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (r_fill_pend)
      r_ring[r_fill_slot][r_fill_col] <= mem_do;
  end

  assign row_cached = w_row_cached;
  assign rd_valid   = r_rd_valid;
  assign row_a      = r_row_a;
  assign row_b      = r_row_b;
  assign row_c      = r_row_c;
  assign wr_ready   = w_wr_ready;
  assign done       = r_done;

endmodule
